// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit period.
// UART_TX_PARITY_EN adds the PARITY state used by the even-parity transmitter build.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 5208;  // 50 MHz / 9600 baud

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Holding clear keeps the count at zero so the first bit starts with a full period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

  assign bit_tick = (count == LAST);

endmodule

// File: rtl/uart_result_tx.sv
// 8N1 UART transmitter for the CPU result byte; tx is registered and idles high.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_result_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx,
  output logic [2:0] state_dbg
);

  // Handshake: a byte moves on the rising edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE and tx_valid is ignored at all other times.

  state_t     state, state_next;
  logic [7:0] shreg, shreg_next;
  logic [2:0] bit_idx, idx_next;
  logic       tx_next;
  logic       bit_tick;
`ifdef UART_TX_PARITY_EN
  logic       par_bit, par_next;
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == IDLE),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      bit_idx <= idx_next;
      tx      <= tx_next;
`ifdef UART_TX_PARITY_EN
      par_bit <= par_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    shreg_next = shreg;
    idx_next   = bit_idx;
`ifdef UART_TX_PARITY_EN
    par_next   = par_bit;
`endif
    case (state)
      IDLE: begin
        if (tx_valid) begin
          state_next = START;
          shreg_next = tx_data;
`ifdef UART_TX_PARITY_EN
          par_next   = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_tick) state_next = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shreg_next = {1'b0, shreg[7:1]};
          idx_next   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // tx is registered from the next state so the line changes on the bit edge itself.
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = par_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  assign tx_ready  = (state == IDLE);
  assign tx_busy   = ~tx_ready;
  assign tx_done   = (state == STOP) && bit_tick;
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_result_tx.sv
// Self-checking bench for uart_result_tx (CLKS_PER_BIT=4): frame-level queue model,
// per-cycle compare, directed literal frames and randomized traffic.
module tb_uart_result_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int N = NB * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx;
  logic [2:0] state_dbg;

  int checks = 0;
  int passed = 0;

  logic       exp_q[$];
  logic [2:0] idle_code = 3'd0;
  bit         have_idle = 1'b0;

  uart_result_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx       (tx),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Model: a line-level picture of each frame, one queue entry per clock cycle.
  function automatic void push_frame(input logic [7:0] d);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^d);
`endif
    bits.push_back(1'b1);
    foreach (bits[k]) for (int r = 0; r < CPB; r++) exp_q.push_back(bits[k]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q.delete();
    else if (exp_q.size() == 0) begin
      if (tx_valid) push_frame(tx_data);
    end else begin
      void'(exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    logic e_tx, e_idle;
    e_idle = (exp_q.size() == 0);
    e_tx   = e_idle ? 1'b1 : exp_q[0];
    check("cyc_tx", 64'(tx), 64'(e_tx));
    check("cyc_ready", 64'(tx_ready), 64'(e_idle));
    check("cyc_busy", 64'(tx_busy), 64'(!e_idle));
    check("cyc_done", 64'(tx_done), 64'(exp_q.size() == 1));
    if (have_idle && e_idle) check("cyc_idle_state", 64'(state_dbg), 64'(idle_code));
  end

  // Present d, let it be accepted on the next edge, then record ncyc cycles (cycle 1 = first START cycle).
  task automatic run_frame(input logic [7:0] d, input logic [7:0] d_after, input bit hold,
                           input bit pre, input int ncyc, output logic [127:0] txv,
                           output int done_cnt, output int first_done, output int rdy_low);
    if (!pre) begin
      @(posedge clk); #1;
      tx_data = d;
      tx_valid = 1'b1;
    end
    @(posedge clk); #1;
    tx_data = d_after;
    if (!hold) tx_valid = 1'b0;
    txv = '0;
    done_cnt = 0;
    first_done = 0;
    rdy_low = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      txv[c-1] = tx;
      if (tx_done) begin
        done_cnt++;
        if (first_done == 0) first_done = c;
      end
      if (!tx_ready) rdy_low++;
    end
  endtask

  // s: hand-written start, 8 data bits LSB first, parity; stop and trailing idle are appended.
  task automatic check_frame(input string name, input int s[$], input logic [127:0] txv);
    logic [63:0] e, m;
    int n;
    e = '0;
    m = '0;
`ifndef UART_TX_PARITY_EN
    s.delete(9);
`endif
    s.push_back(1);
    n = s.size() * CPB;
    foreach (s[k]) for (int r = 0; r < CPB; r++) e[k*CPB+r] = s[k][0];
    e[n] = 1'b1;
    for (int i = 0; i <= n; i++) m[i] = 1'b1;
    check(name, txv[63:0] & m, e);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] txv;
    int dc, fd, rl;

    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_ready", 64'(tx_ready), 64'd1);
    check("rst_busy", 64'(tx_busy), 64'd0);
    check("rst_done", 64'(tx_done), 64'd0);
    idle_code = state_dbg;
    have_idle = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;

    // A5: stream 0,1,0,1,0,0,1,0,1,1; done in cycle N; ready low cycles 1..N
    run_frame(8'hA5, 8'hA5, 0, 0, N + 1, txv, dc, fd, rl);
    check_frame("a5_frame", '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0}, txv);
    check("a5_done_cycle", 64'(fd), 64'(N));
    check("a5_done_count", 64'(dc), 64'd1);
    check("a5_ready_low", 64'(rl), 64'(N));
    idle_cycles(3);

    // 00 then FF back-to-back with tx_valid held high
    run_frame(8'h00, 8'hFF, 1, 0, 2 * N + 1, txv, dc, fd, rl);
    tx_valid = 1'b0;
    check("b2b_gap", 64'(txv[N+1 -: 6]), 64'b011111);
    check("b2b_first_low", 64'(txv[CPB*8 +: CPB]), 64'd0);
    check("b2b_ff_data", 64'(txv[N+1+CPB +: 8*CPB]), 64'hFFFF_FFFF);
    check("b2b_done_count", 64'(dc), 64'd2);
    check("b2b_first_done", 64'(fd), 64'(N));
    check("b2b_ready_low", 64'(rl), 64'(2 * N));
    idle_cycles(3);

    // 3C pulsed mid-frame of 55 must be dropped
    fork
      run_frame(8'h55, 8'h55, 0, 0, N + 20, txv, dc, fd, rl);
      begin
        repeat (16) @(posedge clk);
        #1 tx_data = 8'h3C;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
      end
    join
    check_frame("drop_55_frame", '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0}, txv);
    check("drop_quiet_line", 64'(txv[N +: 20]), 64'hF_FFFF);
    check("drop_done_count", 64'(dc), 64'd1);
    idle_cycles(2);

    // Reset during data bit 3 of F0, then 81 on the first edge after release
    run_frame(8'hF0, 8'hF0, 0, 0, 18, txv, dc, fd, rl);
    check("abort_pre_line", 64'(txv[17:0]), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_tx", 64'(tx), 64'd1);
    check("abort_ready", 64'(tx_ready), 64'd1);
    check("abort_done", 64'(tx_done), 64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tx_data = 8'h81;
    tx_valid = 1'b1;
    run_frame(8'h81, 8'h81, 0, 1, N + 1, txv, dc, fd, rl);
    check_frame("post_rst_81_frame", '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0}, txv);
    check("post_rst_81_done", 64'(fd), 64'(N));
    idle_cycles(2);

    // 12 then EE one cycle after acceptance
    run_frame(8'h12, 8'hEE, 0, 0, N + 1, txv, dc, fd, rl);
    check_frame("late_change_12", '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0}, txv);
    idle_cycles(2);

`ifdef UART_TX_PARITY_EN
    run_frame(8'h07, 8'h07, 0, 0, N + 1, txv, dc, fd, rl);
    check_frame("par_07_frame", '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1}, txv);
    check("par_07_bit", 64'(txv[36]), 64'd1);
    check("par_07_len", 64'(fd), 64'd44);
    idle_cycles(2);
    run_frame(8'h03, 8'h03, 0, 0, N + 1, txv, dc, fd, rl);
    check_frame("par_03_frame", '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0}, txv);
    check("par_03_bit", 64'(txv[36]), 64'd0);
    check("par_03_len", 64'(fd), 64'd44);
    idle_cycles(2);
`endif

    // Randomized traffic checked by the per-cycle model
    for (int it = 0; it < 30; it++) begin
      idle_cycles($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: begin
          tx_data = 8'($urandom);
          tx_valid = 1'b1;
          idle_cycles(1);
          tx_valid = 1'b0;
          idle_cycles($urandom_range(0, N + 4));
        end
        1: begin
          tx_valid = 1'b1;
          repeat ($urandom_range(1, 90)) begin
            tx_data = 8'($urandom);
            idle_cycles(1);
          end
          tx_valid = 1'b0;
        end
        default: begin
          tx_data = 8'($urandom);
          tx_valid = 1'b1;
          idle_cycles(1);
          tx_valid = 1'b0;
          idle_cycles($urandom_range(1, N + 2));
          rst_n = 1'b0;
          idle_cycles($urandom_range(1, 2));
          rst_n = 1'b1;
        end
      endcase
    end
    tx_valid = 1'b0;
    idle_cycles(N + 4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
